yolo_frame_sched: RTL and testbench

- Per-frame sequencer between the input/output stream FIFO interfaces and the yolo_core datapath.
- On a start pulse it arms a frame and gates core reads from the input FIFO until the configured number of input beats has been consumed.
- It gates core writes to the output FIFO, counts output beats and asserts osif_last_din on the final beat. It then reports done, or a length error.
- Software/top-level sees a start/busy/done/error handshake; yolo_core sees request/grant strobes.

---
 rtl/yolo_sched_pkg.sv | 13 +
 rtl/yolo_beat_cnt.sv | 38 +++
 rtl/yolo_frame_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_yolo_frame_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_sched_pkg.sv
// Shared constants for the yolo frame scheduler: FSM state encoding and
// default widths for the beat counters and the optional performance counters.
package yolo_sched_pkg;

    localparam int CNT_W_DFLT  = 20;
    localparam int PERF_W_DFLT = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/yolo_beat_cnt.sv
// Beat counter cleared at frame start, stepped once per granted beat.
// below: count has not yet reached limit. last: the next beat is the final one.
module yolo_beat_cnt
    import yolo_sched_pkg::*;
#(
    parameter int W = CNT_W_DFLT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         below,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Counter state: synchronous reset, clear on frame arm, step on grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Terminal-count flags; widened compare avoids wrap when limit is zero.
    always_comb begin
        below = (cnt_r < limit);
        last  = below && (({1'b0, cnt_r} + {{W{1'b0}}, 1'b1}) == {1'b0, limit});
    end

endmodule

// File: rtl/yolo_frame_sched.sv
// Per-frame sequencer between the stream FIFOs and yolo_core.
// Optional build macro YOLO_FRAME_SCHED_PERF_EN adds saturating stall/cycle
// performance counters (perf_in_stall, perf_out_stall, perf_cycles).
module yolo_frame_sched
    import yolo_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
`ifdef YOLO_FRAME_SCHED_PERF_EN
    ,
    parameter int PERF_W = PERF_W_DFLT
`endif
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_in_beats,
    input  logic [CNT_W-1:0] cfg_out_beats,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             core_start,
    input  logic             core_rd_req,
    output logic             core_rd_gnt,
    input  logic             isif_empty_n,
    input  logic             isif_last_dout,
    output logic             isif_read,
    input  logic             core_wr_req,
    output logic             core_wr_gnt,
    input  logic             osif_full_n,
    output logic             osif_write,
    output logic             osif_last_din
`ifdef YOLO_FRAME_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_in_stall,
    output logic [PERF_W-1:0] perf_out_stall,
    output logic [PERF_W-1:0] perf_cycles
`endif
);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] in_lim_r;
    logic [CNT_W-1:0] out_lim_r;
    logic             in_cmpl_r;
    logic             err_r;
    logic             busy_r;
    logic             done_r;
    logic             core_start_r;

    logic             start_acc_s;
    logic             rd_gnt_s;
    logic             wr_gnt_s;
    logic             out_en_s;
    logic             in_below_s;
    logic             in_last_s;
    logic             out_below_s;
    logic             out_last_s;
    logic             in_done_now_s;
    logic             out_done_now_s;
    logic             err_set_s;

    // Transfer gating and completion decode for the current cycle.
    always_comb begin
        start_acc_s    = cfg_start && (state_r == ST_IDLE);
        out_en_s       = (state_r == ST_RUN) || (state_r == ST_FLUSH);
        rd_gnt_s       = (state_r == ST_RUN) && core_rd_req && isif_empty_n && !in_cmpl_r;
        wr_gnt_s       = out_en_s && core_wr_req && osif_full_n && out_below_s;
        // A beat closes the input either by count or by an early TLAST.
        in_done_now_s  = in_cmpl_r || (rd_gnt_s && (in_last_s || isif_last_dout));
        out_done_now_s = !out_below_s || (wr_gnt_s && out_last_s);
        // TLAST must coincide exactly with the counted last beat.
        err_set_s      = rd_gnt_s && (in_last_s != isif_last_dout);
    end

    yolo_beat_cnt #(.W(CNT_W)) u_in_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (start_acc_s),
        .inc   (rd_gnt_s),
        .limit (in_lim_r),
        .below (in_below_s),
        .last  (in_last_s)
    );

    yolo_beat_cnt #(.W(CNT_W)) u_out_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (start_acc_s),
        .inc   (wr_gnt_s),
        .limit (out_lim_r),
        .below (out_below_s),
        .last  (out_last_s)
    );

    // Next-state logic; input and final output in one cycle skip FLUSH.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_done_now_s && out_done_now_s) begin
                    state_nx_s = ST_FIN;
                end else if (in_done_now_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (out_done_now_s) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM, frame configuration, input-complete flag and status registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r      <= ST_IDLE;
            in_lim_r     <= {CNT_W{1'b0}};
            out_lim_r    <= {CNT_W{1'b0}};
            in_cmpl_r    <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            core_start_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            done_r       <= (state_nx_s == ST_FIN);
            core_start_r <= start_acc_s;
            if (start_acc_s) begin
                in_lim_r  <= cfg_in_beats;
                out_lim_r <= cfg_out_beats;
                // A zero-length input is complete on entry to RUN.
                in_cmpl_r <= (cfg_in_beats == {CNT_W{1'b0}});
                err_r     <= 1'b0;
            end else begin
                in_lim_r  <= in_lim_r;
                out_lim_r <= out_lim_r;
                in_cmpl_r <= in_cmpl_r || (rd_gnt_s && (in_last_s || isif_last_dout));
                err_r     <= err_r || err_set_s;
            end
        end
    end

    // Output drive: status from registers, grants are same-cycle handshakes.
    always_comb begin
        busy          = busy_r;
        done          = done_r;
        err_len       = err_r;
        core_start    = core_start_r;
        core_rd_gnt   = rd_gnt_s;
        isif_read     = rd_gnt_s;
        core_wr_gnt   = wr_gnt_s;
        osif_write    = wr_gnt_s;
        osif_last_din = wr_gnt_s && out_last_s;
    end

`ifdef YOLO_FRAME_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_in_r;
    logic [PERF_W-1:0] perf_out_r;
    logic [PERF_W-1:0] perf_cyc_r;
    logic              in_stall_s;
    logic              out_stall_s;

    // Stall qualifiers for the performance counters.
    always_comb begin
        in_stall_s  = (state_r == ST_RUN) && core_rd_req && !isif_empty_n && !in_cmpl_r;
        out_stall_s = out_en_s && out_below_s && core_wr_req && !osif_full_n;
    end

    // Saturating counters, cleared on accepted start, frozen while idle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            perf_in_r  <= {PERF_W{1'b0}};
            perf_out_r <= {PERF_W{1'b0}};
            perf_cyc_r <= {PERF_W{1'b0}};
        end else if (start_acc_s) begin
            perf_in_r  <= {PERF_W{1'b0}};
            perf_out_r <= {PERF_W{1'b0}};
            perf_cyc_r <= {PERF_W{1'b0}};
        end else begin
            if (in_stall_s && !(&perf_in_r)) begin
                perf_in_r <= perf_in_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                perf_in_r <= perf_in_r;
            end
            if (out_stall_s && !(&perf_out_r)) begin
                perf_out_r <= perf_out_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                perf_out_r <= perf_out_r;
            end
            if (busy_r && !(&perf_cyc_r)) begin
                perf_cyc_r <= perf_cyc_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                perf_cyc_r <= perf_cyc_r;
            end
        end
    end

    // Performance outputs come straight from their registers.
    always_comb begin
        perf_in_stall  = perf_in_r;
        perf_out_stall = perf_out_r;
        perf_cycles    = perf_cyc_r;
    end
`endif

endmodule

// File: tb/tb_yolo_frame_sched.sv
// Self-checking bench for yolo_frame_sched: frames are driven per scenario,
// expected TLAST flags of output beats are queued up front and compared
// against the beats the DUT actually writes.
module tb_yolo_frame_sched;

    localparam int CNT_W = 20;
`ifdef YOLO_FRAME_SCHED_PERF_EN
    localparam int PERF_W = 32;
`endif

    logic             aclk;
    logic             aresetn;
    logic             cfg_start;
    logic [CNT_W-1:0] cfg_in_beats;
    logic [CNT_W-1:0] cfg_out_beats;
    logic             busy;
    logic             done;
    logic             err_len;
    logic             core_start;
    logic             core_rd_req;
    logic             core_rd_gnt;
    logic             isif_empty_n;
    logic             isif_last_dout;
    logic             isif_read;
    logic             core_wr_req;
    logic             core_wr_gnt;
    logic             osif_full_n;
    logic             osif_write;
    logic             osif_last_din;
`ifdef YOLO_FRAME_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_in_stall;
    logic [PERF_W-1:0] perf_out_stall;
    logic [PERF_W-1:0] perf_cycles;
`endif

    yolo_frame_sched #(.CNT_W(CNT_W)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_start      (cfg_start),
        .cfg_in_beats   (cfg_in_beats),
        .cfg_out_beats  (cfg_out_beats),
        .busy           (busy),
        .done           (done),
        .err_len        (err_len),
        .core_start     (core_start),
        .core_rd_req    (core_rd_req),
        .core_rd_gnt    (core_rd_gnt),
        .isif_empty_n   (isif_empty_n),
        .isif_last_dout (isif_last_dout),
        .isif_read      (isif_read),
        .core_wr_req    (core_wr_req),
        .core_wr_gnt    (core_wr_gnt),
        .osif_full_n    (osif_full_n),
        .osif_write     (osif_write),
        .osif_last_din  (osif_last_din)
`ifdef YOLO_FRAME_SCHED_PERF_EN
        ,
        .perf_in_stall  (perf_in_stall),
        .perf_out_stall (perf_out_stall),
        .perf_cycles    (perf_cycles)
`endif
    );

    int   n_checks;
    int   n_fail;
    logic exp_q[$];
    logic obs_q[$];

    // Per-frame observations collected by run_frame.
    int   f_rd, f_wr, f_done, f_done_cyc, f_cs, f_cs_cyc, f_viol;
    logic f_err1, f_err_end, f_busy_after;

    // Free-running clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Stimulus/sampling engine: one loop iteration per clock. Inputs change
    // 1 time unit after the rising edge, outputs are sampled on the falling
    // edge. tl = input beat carrying TLAST (0 = none), rs_at = cycle of an
    // extra start pulse (-1 = none), output FIFO stalls st_len cycles once
    // st_after beats have been written.
    task automatic run_frame(input int in_b, input int out_b, input int tl,
                             input int rs_at, input int st_after, input int st_len);
        int stall_left;
        stall_left   = st_len;
        f_rd = 0; f_wr = 0; f_done = 0; f_done_cyc = -1; f_cs = 0; f_cs_cyc = -1; f_viol = 0;
        f_err1 = 1'bx; f_err_end = 1'bx; f_busy_after = 1'bx;
        obs_q.delete();
        for (int i = 0; i < 80; i++) begin
            cfg_start = (i == 0) || (i == rs_at);
            if (i == rs_at) begin
                cfg_in_beats  = 20'd1;
                cfg_out_beats = 20'd1;
            end else begin
                cfg_in_beats  = CNT_W'(in_b);
                cfg_out_beats = CNT_W'(out_b);
            end
            core_rd_req    = 1'b1;
            core_wr_req    = 1'b1;
            isif_empty_n   = 1'b1;
            isif_last_dout = (tl != 0) && (f_rd + 1 == tl);
            if (i > 0 && stall_left > 0 && f_wr >= st_after) begin
                osif_full_n = 1'b0;
                stall_left--;
            end else begin
                osif_full_n = 1'b1;
            end
            @(negedge aclk);
            if (isif_read) f_rd++;
            if (osif_write) begin
                f_wr++;
                obs_q.push_back(osif_last_din);
                if (!osif_full_n) f_viol++;
            end
            if (i == 1) f_err1 = err_len;
            if (done) begin
                f_done++;
                f_done_cyc = i;
            end
            if (core_start) begin
                f_cs++;
                f_cs_cyc = i;
            end
            if (f_done > 0 && i == f_done_cyc + 2) begin
                f_busy_after = busy;
                f_err_end    = err_len;
                break;
            end
            @(posedge aclk); #1;
        end
        cfg_start   = 1'b0;
        core_rd_req = 1'b0;
        core_wr_req = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        aresetn      = 1'b0;
        cfg_start    = 1'b0;
        core_rd_req  = 1'b1;
        core_wr_req  = 1'b1;
        isif_empty_n = 1'b1;
        osif_full_n  = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_len); end
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        n_checks++;
        if ({core_rd_gnt, isif_read, core_wr_gnt, osif_write, osif_last_din} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_grants got=%b exp=00000",
                     {core_rd_gnt, isif_read, core_wr_gnt, osif_write, osif_last_din});
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        core_rd_req = 1'b0;
        core_wr_req = 1'b0;
    endtask

    task automatic test_basic();
        logic o, e;
        for (int k = 0; k < 2; k++) exp_q.push_back(k == 1);
        run_frame(4, 2, 4, -1, 0, 0);
        n_checks++; if (f_rd != 4) begin n_fail++; $display("FAIL basic_reads got=%0d exp=4", f_rd); end
        n_checks++; if (f_wr != 2) begin n_fail++; $display("FAIL basic_writes got=%0d exp=2", f_wr); end
        n_checks++; if (f_done != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", f_done); end
        n_checks++; if (f_done_cyc != 5) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=5", f_done_cyc); end
        n_checks++; if (f_cs != 1 || f_cs_cyc != 1) begin n_fail++; $display("FAIL basic_core_start got=%0d@%0d exp=1@1", f_cs, f_cs_cyc); end
        n_checks++; if (f_err_end !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", f_err_end); end
        n_checks++; if (f_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", f_busy_after); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_last got=%b exp=%b", o, e); end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL basic_beats left_exp=%0d left_obs=%0d exp=0/0", exp_q.size(), obs_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_tlast_early();
        logic o, e;
        for (int k = 0; k < 3; k++) exp_q.push_back(k == 2);
        run_frame(4, 3, 2, -1, 0, 0);
        n_checks++; if (f_rd != 2) begin n_fail++; $display("FAIL early_reads got=%0d exp=2", f_rd); end
        n_checks++; if (f_err_end !== 1'b1) begin n_fail++; $display("FAIL early_err got=%b exp=1", f_err_end); end
        n_checks++; if (f_done != 1 || f_done_cyc != 4) begin n_fail++; $display("FAIL early_done got=%0d@%0d exp=1@4", f_done, f_done_cyc); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL early_last got=%b exp=%b", o, e); end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL early_beats left_exp=%0d left_obs=%0d exp=0/0", exp_q.size(), obs_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_no_tlast();
        run_frame(3, 1, 0, -1, 0, 0);
        n_checks++; if (f_err1 !== 1'b0) begin n_fail++; $display("FAIL notlast_err_cleared got=%b exp=0", f_err1); end
        n_checks++; if (f_rd != 3) begin n_fail++; $display("FAIL notlast_reads got=%0d exp=3", f_rd); end
        n_checks++; if (f_err_end !== 1'b1) begin n_fail++; $display("FAIL notlast_err got=%b exp=1", f_err_end); end
        n_checks++; if (f_done != 1 || f_done_cyc != 4) begin n_fail++; $display("FAIL notlast_done got=%0d@%0d exp=1@4", f_done, f_done_cyc); end
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL notlast_writes got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_out_stall();
        logic o, e;
        for (int k = 0; k < 4; k++) exp_q.push_back(k == 3);
        run_frame(2, 4, 2, -1, 1, 5);
        n_checks++; if (f_viol != 0) begin n_fail++; $display("FAIL stall_write_while_full got=%0d exp=0", f_viol); end
        n_checks++; if (f_done_cyc != 10) begin n_fail++; $display("FAIL stall_done_cycle got=%0d exp=10", f_done_cyc); end
        n_checks++; if (f_err_end !== 1'b0) begin n_fail++; $display("FAIL stall_err got=%b exp=0", f_err_end); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL stall_last got=%b exp=%b", o, e); end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL stall_beats left_exp=%0d left_obs=%0d exp=0/0", exp_q.size(), obs_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_zero_len();
        run_frame(0, 0, 0, -1, 0, 0);
        n_checks++; if (f_done != 1 || f_done_cyc != 2) begin n_fail++; $display("FAIL zero_done got=%0d@%0d exp=1@2", f_done, f_done_cyc); end
        n_checks++; if (f_rd != 0 || f_wr != 0) begin n_fail++; $display("FAIL zero_xfers got=%0d/%0d exp=0/0", f_rd, f_wr); end
        n_checks++; if (f_err_end !== 1'b0) begin n_fail++; $display("FAIL zero_err got=%b exp=0", f_err_end); end
    endtask

    task automatic test_back_to_back();
        logic o, e;
        // Second start pulse mid-frame with different config must be ignored.
        for (int k = 0; k < 2; k++) exp_q.push_back(k == 1);
        run_frame(4, 2, 4, 2, 0, 0);
        n_checks++; if (f_rd != 4) begin n_fail++; $display("FAIL ignore_reads got=%0d exp=4", f_rd); end
        n_checks++; if (f_done != 1 || f_done_cyc != 5) begin n_fail++; $display("FAIL ignore_done got=%0d@%0d exp=1@5", f_done, f_done_cyc); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ignore_last got=%b exp=%b", o, e); end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL ignore_beats left_exp=%0d left_obs=%0d exp=0/0", exp_q.size(), obs_q.size());
        end
        exp_q.delete();
        // Output length zero: FLUSH is skipped once input completes.
        run_frame(2, 0, 2, -1, 0, 0);
        n_checks++; if (f_rd != 2 || f_wr != 0) begin n_fail++; $display("FAIL out0_xfers got=%0d/%0d exp=2/0", f_rd, f_wr); end
        n_checks++; if (f_done != 1 || f_done_cyc != 3) begin n_fail++; $display("FAIL out0_done got=%0d@%0d exp=1@3", f_done, f_done_cyc); end
    endtask

    task automatic test_reset_mid();
        int rd;
        rd = 0;
        cfg_in_beats   = 20'd6;
        cfg_out_beats  = 20'd6;
        cfg_start      = 1'b1;
        core_rd_req    = 1'b1;
        core_wr_req    = 1'b0;
        isif_empty_n   = 1'b1;
        isif_last_dout = 1'b0;
        osif_full_n    = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            if (isif_read) rd++;
            @(posedge aclk); #1;
        end
        n_checks++; if (rd != 2) begin n_fail++; $display("FAIL rstmid_reads got=%0d exp=2", rd); end
        core_rd_req = 1'b0;
        aresetn     = 1'b0;
        @(posedge aclk); #1;
        aresetn     = 1'b1;
        core_rd_req = 1'b1;
        core_wr_req = 1'b1;
        @(negedge aclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (isif_read !== 1'b0 || osif_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_grants got=%b%b exp=00", isif_read, osif_write); end
        @(posedge aclk); #1;
        core_rd_req = 1'b0;
        core_wr_req = 1'b0;
        run_frame(4, 2, 4, -1, 0, 0);
        n_checks++; if (f_rd != 4 || f_wr != 2) begin n_fail++; $display("FAIL rstmid_rerun_xfers got=%0d/%0d exp=4/2", f_rd, f_wr); end
        n_checks++; if (f_done != 1 || f_done_cyc != 5) begin n_fail++; $display("FAIL rstmid_rerun_done got=%0d@%0d exp=1@5", f_done, f_done_cyc); end
        n_checks++; if (f_err_end !== 1'b0) begin n_fail++; $display("FAIL rstmid_rerun_err got=%b exp=0", f_err_end); end
        n_checks++; if (obs_q.size() != 2 || obs_q[1] !== 1'b1 || obs_q[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_rerun_last got=%0d beats exp=2 with last on 2nd", obs_q.size()); end
    endtask

    // Scenario sequencer.
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        aresetn        = 1'b0;
        cfg_start      = 1'b0;
        cfg_in_beats   = 20'd0;
        cfg_out_beats  = 20'd0;
        core_rd_req    = 1'b0;
        core_wr_req    = 1'b0;
        isif_empty_n   = 1'b0;
        isif_last_dout = 1'b0;
        osif_full_n    = 1'b0;
        test_reset();
        test_basic();
        test_tlast_early();
        test_no_tlast();
        test_out_stall();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
